barrett_mod_reduce: RTL and testbench

//  Parametrised Barrett reduction r = a mod p for a 2W-bit operand and a W-bit modulus.

---
 rtl/barrett_mod_reduce.sv | 229 ++++++++++++++++++++++
 tb/tb_barrett_mod_reduce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/barrett_mod_reduce.sv
// barrett_mod_reduce: sequential Barrett reduction r = (+/-a) mod p.
// The request is captured on accept. The reduction runs through a fixed
// schedule of multiply, subtract and correct steps. The result is held
// until the consumer accepts it.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake (in_ready high only in IDLE)
//   in_a, in_sign              2W-bit magnitude and sign of the operand
//   in_p, in_mu                modulus (msb must be set) and floor(2^(2W)/p)
//   in_tag                     opaque tag returned with the result
//   out_valid/out_ready        result handshake
//   out_r, out_err, out_tag    residue, non-normalised-modulus flag, tag
module barrett_mod_reduce #(
    parameter int unsigned W          = 64,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*W-1:0]     in_a,
    input  logic               in_sign,
    input  logic [W-1:0]       in_p,
    input  logic [W:0]         in_mu,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_r,
    output logic               out_err,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned PW    = 2 * W + 2;
    localparam int unsigned CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [W+1:0]     TWO_W1   = {2'b01, {(W + 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, Q1, MUL_MU, MUL_P, SUB, CORR1, CORR2, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W:0]         opa_q, opa_d;
    logic [W:0]         opb_q, opb_d;
    logic [W:0]         a_lo_q, a_lo_d;
    logic [W-1:0]       p_q, p_d;
    logic               sign_q, sign_d;
    logic               err_q, err_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [W+1:0]       r_q, r_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_r_q, out_r_d;
    logic               out_err_q, out_err_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;

    logic [PW-1:0]      pipe_q [MUL_STAGES];
    logic [PW-1:0]      prod;
    logic [PW-1:0]      pipe_out;
    logic               mul_en;
    logic [W+1:0]       p_ext;
    logic [W+1:0]       sub_diff;
    logic [W+1:0]       sub_r;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_err   = out_err_q;
    assign out_tag   = out_tag_q;

    // Shared (W+1)x(W+1) multiplier; the register chain lets synthesis retime it.
    assign prod     = PW'(opa_q) * PW'(opb_q);
    assign pipe_out = pipe_q[MUL_STAGES-1];
    assign mul_en   = (state_q == Q1) || (state_q == MUL_MU) || (state_q == MUL_P);

    // Low W+1 bits of a minus (q3*p mod 2^(W+1)), wrapped into [0, 2^(W+1)).
    assign p_ext    = {2'b00, p_q};
    assign sub_diff = (W + 2)'(a_lo_q) - (W + 2)'(pipe_out[W:0]);
    assign sub_r    = sub_diff[W+1] ? (sub_diff + TWO_W1) : sub_diff;

    // Multiplier pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) pipe_q[i] <= '0;
        end else if (mul_en) begin
            pipe_q[0] <= prod;
            for (int i = 1; i < int'(MUL_STAGES); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            a_lo_q      <= '0;
            p_q         <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            tag_q       <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_err_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            a_lo_q      <= a_lo_d;
            p_q         <= p_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
            r_q         <= r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_err_q   <= out_err_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        a_lo_d      = a_lo_q;
        p_d         = p_q;
        sign_d      = sign_q;
        err_d       = err_q;
        tag_d       = tag_q;
        r_d         = r_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_err_d   = out_err_q;
        out_tag_d   = out_tag_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    // q1 = a >> (W-1) is pure wiring, so capture it directly
                    opa_d      = (W + 1)'(in_a >> (W - 1));
                    opb_d      = in_mu;
                    a_lo_d     = in_a[W:0];
                    p_d        = in_p;
                    sign_d     = in_sign;
                    tag_d      = in_tag;
                    r_d        = '0;
                    cnt_d      = '0;
                    if (!in_p[W-1]) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = Q1;
                    end
                end
            end
            Q1: begin
                cnt_d   = '0;
                state_d = MUL_MU;
            end
            MUL_MU: begin
                if (cnt_q == CNT_LAST) begin
                    // q2 has reached the pipe tail: q3 = q2 >> (W+1), next multiply by p
                    cnt_d   = '0;
                    opa_d   = (W + 1)'(pipe_out >> (W + 1));
                    opb_d   = {1'b0, p_q};
                    state_d = MUL_P;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MUL_P: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SUB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SUB: begin
                r_d     = sub_r;
                state_d = CORR1;
            end
            CORR1: begin
                if (r_q >= p_ext) r_d = r_q - p_ext;
                state_d = CORR2;
            end
            CORR2: begin
                if (r_q >= p_ext) r_d = r_q - p_ext;
                state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_err_d   = err_q;
                    out_tag_d   = tag_q;
                    if (err_q) begin
                        out_r_d = '0;
                    end else if (sign_q && (r_q != '0)) begin
                        out_r_d = p_q - W'(r_q);
                    end else begin
                        out_r_d = W'(r_q);
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_barrett_mod_reduce.sv
// tb_barrett_mod_reduce: directed and randomised checks of barrett_mod_reduce.
// A W=8 instance runs hand-computed vectors, the latency checks and the
// reset-abort case. A W=64 instance runs random traffic against a plain
// a mod p model, with random output stalls.
module tb_barrett_mod_reduce;

    localparam int unsigned S = 2;
    localparam logic [63:0] P64 = 64'h989D_4E43_F57F_CF45;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // W=8 instance signals
    logic        v8, rdy8, sign8, ov8, ordy8, err8;
    logic [15:0] a8;
    logic [7:0]  p8, r8;
    logic [8:0]  mu8;
    logic [3:0]  tag8, otag8;

    // W=64 instance signals
    logic         v64, rdy64, sign64, ov64, ordy64, err64;
    logic [127:0] a64;
    logic [63:0]  p64, r64;
    logic [64:0]  mu64;
    logic [64:0]  mu64_ref;
    logic [3:0]   tag64, otag64;

    logic [68:0]  exp_q[$];

    barrett_mod_reduce #(.W(8), .MUL_STAGES(S), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_sign(sign8),
        .in_p(p8), .in_mu(mu8), .in_tag(tag8),
        .out_valid(ov8), .out_ready(ordy8), .out_r(r8), .out_err(err8), .out_tag(otag8)
    );

    barrett_mod_reduce #(.W(64), .MUL_STAGES(S), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64), .in_ready(rdy64), .in_a(a64), .in_sign(sign64),
        .in_p(p64), .in_mu(mu64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(ordy64), .out_r(r64), .out_err(err64), .out_tag(otag64)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {err, (+/-a) mod p} from plain modular arithmetic
    function automatic logic [64:0] model(input logic [127:0] a, input logic s,
                                          input logic [63:0] p, input int w);
        logic [63:0] r;
        if (p[w-1] == 1'b0) return {1'b1, 64'd0};
        r = 64'(a % {64'd0, p});
        if (s && (r != 64'd0)) r = p - r;
        return {1'b0, r};
    endfunction

    // One request on the W=8 instance with literal expectations
    task automatic run8(input logic [15:0] a, input logic s, input logic [7:0] p,
                        input logic [8:0] mu, input logic [3:0] tag,
                        input logic [7:0] exp_r, input logic exp_err, input int exp_lat);
        int lat;
        int w;
        logic [64:0] m;
        logic [7:0] held_r;
        @(negedge clk);
        a8 = a; sign8 = s; p8 = p; mu8 = mu; tag8 = tag; v8 = 1'b1; ordy8 = 1'b0;
        w = 0;
        while (!rdy8 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready8", rdy8, 1'b1);
        @(negedge clk);
        // scramble inputs: the captured request must be unaffected
        v8 = 1'b0; a8 = 16'($urandom); p8 = 8'($urandom); mu8 = 9'($urandom);
        tag8 = 4'($urandom); sign8 = ~s;
        check("busy8", rdy8, 1'b0);
        lat = 1;
        while (!ov8 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", lat - 1, exp_lat);
        check("r8", r8, exp_r);
        check("err8", err8, exp_err);
        check("tag8", otag8, tag);
        m = model({112'd0, a}, s, {56'd0, p}, 8);
        check("model8", {err8, r8}, {m[64], m[7:0]});
        held_r = r8;
        repeat (2) @(negedge clk);
        check("hold8", {ov8, r8, otag8}, {1'b1, held_r, tag});
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        check("release8", {ov8, rdy8}, 2'b01);
    endtask

    // Random traffic on the W=64 instance; in-order scoreboard with stalls
    task automatic run64(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [127:0] a;
                    logic s;
                    int w;
                    a = {$urandom, $urandom, $urandom, $urandom};
                    s = 1'($urandom_range(0, 1));
                    if (i == 0) begin a = '0; s = 1'b0; end
                    if (i == 1) begin a = {64'd0, P64}; s = 1'b0; end
                    if (i == 2) begin a = '1; s = 1'b0; end
                    if (i == 3) begin a = {64'd0, P64}; s = 1'b1; end
                    if (i == 4) begin a = {64'd0, P64 - 64'd1}; s = 1'b1; end
                    a64 = a; sign64 = s; tag64 = 4'(i); p64 = P64; mu64 = mu64_ref; v64 = 1'b1;
                    w = 0;
                    while (!rdy64 && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!rdy64) check("ready64_timeout", rdy64, 1'b1);
                    exp_q.push_back({4'(i), model(a, s, P64, 64)});
                    @(negedge clk);
                    v64 = 1'b0; a64 = {$urandom, $urandom, $urandom, $urandom};
                    sign64 = ~s; p64 = 64'($urandom); tag64 = 4'($urandom);
                end
            end
            begin
                int done = 0;
                int cyc = 0;
                logic held = 1'b0;
                logic [68:0] prev = '0;
                logic [68:0] cur;
                while (done < n && cyc < n * 40) begin
                    @(negedge clk);
                    cyc++;
                    cur = {otag64, err64, r64};
                    if (ov64) begin
                        if (held) begin
                            check("stable64", cur, prev);
                        end else if (exp_q.size() == 0) begin
                            check("unexpected64", ov64, 1'b0);
                        end else begin
                            check("result64", cur, exp_q[0]);
                        end
                        prev = cur;
                    end
                    ordy64 = ($urandom_range(0, 3) != 0);
                    if (ov64 && ordy64) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        done++;
                        held = 1'b0;
                    end else if (ov64) begin
                        held = 1'b1;
                    end
                end
                check("done64", done, n);
                @(negedge clk);
                ordy64 = 1'b0;
            end
        join
    endtask

    initial begin
        int saw;
        logic [128:0] num;
        rst = 1'b1;
        v8 = 1'b0; a8 = '0; sign8 = 1'b0; p8 = '0; mu8 = '0; tag8 = '0; ordy8 = 1'b0;
        v64 = 1'b0; a64 = '0; sign64 = 1'b0; p64 = '0; mu64 = '0; tag64 = '0; ordy64 = 1'b0;
        num = 129'd1 << 128;
        mu64_ref = 65'(num / {65'd0, P64});
        repeat (3) @(negedge clk);
        check("reset8", {rdy8, ov8, r8, err8, otag8}, {1'b1, 1'b0, 8'd0, 1'b0, 4'd0});
        check("reset64", {rdy64, ov64, r64, err64, otag64}, {1'b1, 1'b0, 64'd0, 1'b0, 4'd0});
        rst = 1'b0;
        @(negedge clk);

        run8(16'hFFFF, 1'b0, 8'd251, 9'h105, 4'h1, 8'd24,  1'b0, 2 * S + 5);
        run8(16'd0,    1'b0, 8'd251, 9'h105, 4'h2, 8'd0,   1'b0, 2 * S + 5);
        run8(16'd251,  1'b0, 8'd251, 9'h105, 4'h3, 8'd0,   1'b0, 2 * S + 5);
        run8(16'd250,  1'b0, 8'd251, 9'h105, 4'h4, 8'd250, 1'b0, 2 * S + 5);
        run8(16'd10,   1'b1, 8'd251, 9'h105, 4'h5, 8'd241, 1'b0, 2 * S + 5);
        run8(16'd251,  1'b1, 8'd251, 9'h105, 4'h6, 8'd0,   1'b0, 2 * S + 5);
        run8(16'd1000, 1'b1, 8'd251, 9'h105, 4'h7, 8'd4,   1'b0, 2 * S + 5);
        run8(16'h1234, 1'b0, 8'd100, 9'h000, 4'hA, 8'd0,   1'b1, 1);

        // Reset three cycles into a request aborts it
        @(negedge clk);
        a8 = 16'd1000; sign8 = 1'b0; p8 = 8'd251; mu8 = 9'h105; tag8 = 4'h9; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov8) saw++;
        end
        check("abort_no_valid", saw, 0);
        check("abort_ready", rdy8, 1'b1);
        run8(16'd1000, 1'b0, 8'd251, 9'h105, 4'hB, 8'd247, 1'b0, 2 * S + 5);

        run64(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
